// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and its datapath/memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [6:0]          Opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                IRWrite;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic [1:0]          ALUOp;
  logic                Branch;
  logic                Jump;
  logic                PCWrite;
  logic                illegal;
  logic                timeout;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  Opcode, imem_ready, dmem_ready,
    output imem_req, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, Branch, Jump, PCWrite, illegal, timeout, retired
  );

  modport slave (
    output Opcode, imem_ready, dmem_ready,
    input  imem_req, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, Branch, Jump, PCWrite, illegal, timeout, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, wait timeout, illegal-opcode trap and retired-instruction counter.
module multicycle_controller #(
  parameter bit          ENABLE_JUMPS = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned RETIRE_W     = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t              state, state_n;
  logic [6:0]          opcode_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                illegal_q, timeout_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                waiting, wait_expired;
  logic                retire_now, trap_illegal, trap_timeout;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR: is_legal = 1'b1;
      OP_JAL, OP_JALR:                 is_legal = ENABLE_JUMPS;
      default:                         is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    waiting      = (state == FETCH && !bus.imem_ready) ||
                   (state == MEM   && !bus.dmem_ready);
    wait_expired = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    retire_now   = 1'b0;
    trap_illegal = 1'b0;
    trap_timeout = 1'b0;
    case (state)
      FETCH: begin
        if (bus.imem_ready) state_n = DECODE;
        else if (wait_expired) begin
          state_n      = TRAP;
          trap_timeout = 1'b1;
        end
      end
      DECODE: begin
        if (is_legal(bus.Opcode)) state_n = EXEC;
        else begin
          state_n      = TRAP;
          trap_illegal = 1'b1;
        end
      end
      EXEC: begin
        case (opcode_q)
          OP_R, OP_I, OP_JAL, OP_JALR: state_n = WB;
          OP_LW, OP_SW:                state_n = MEM;
          OP_BR: begin
            state_n    = FETCH;
            retire_now = 1'b1;
          end
          default:                     state_n = TRAP;
        endcase
      end
      MEM: begin
        if (bus.dmem_ready) begin
          if (opcode_q == OP_LW) state_n = WB;
          else begin
            state_n    = FETCH;
            retire_now = 1'b1;
          end
        end else if (wait_expired) begin
          state_n      = TRAP;
          trap_timeout = 1'b1;
        end
      end
      WB: begin
        state_n    = FETCH;
        retire_now = 1'b1;
      end
      default: state_n = TRAP;
    endcase
  end

  // wait_cnt only ever runs while stalled in FETCH/MEM, so any other cycle
  // (including every state entry) leaves it cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state == DECODE) opcode_q <= bus.Opcode;
      if (waiting) wait_cnt <= wait_cnt + WAIT_W'(1);
      else         wait_cnt <= '0;
      if (trap_illegal) illegal_q <= 1'b1;
      if (trap_timeout) timeout_q <= 1'b1;
      if (retire_now)   retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  // Enables are forced low for the whole reset pulse, not just from the next edge.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.PCWrite  = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.IRWrite  = bus.imem_ready;
        end
        EXEC: begin
          case (opcode_q)
            OP_R:         bus.ALUOp = 2'b10;
            OP_I: begin
              bus.ALUOp  = 2'b11;
              bus.ALUSrc = 1'b1;
            end
            OP_LW, OP_SW: bus.ALUSrc = 1'b1;
            OP_BR: begin
              bus.ALUOp  = 2'b01;
              bus.Branch = 1'b1;
            end
            OP_JAL:       bus.Jump = 1'b1;
            OP_JALR: begin
              bus.Jump   = 1'b1;
              bus.ALUSrc = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.ALUSrc   = 1'b1;
          bus.MemRead  = (opcode_q == OP_LW);
          bus.MemWrite = (opcode_q == OP_SW);
          bus.PCWrite  = (opcode_q == OP_SW) && bus.dmem_ready;
        end
        WB: begin
          bus.RegWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.MemtoReg = (opcode_q == OP_LW);
          bus.Jump     = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.retired = retired_q;

endmodule
